// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// Bundles the signals between the EX/MEM pipeline register, the load/store
// sequencer, the word-wide data memory and the MEM/WB register.
//   req_*      : memory instruction from EX/MEM (valid, op, addr, wdata, pc, rd)
//   stall      : upstream freeze request
//   dm_*       : data memory port (read/write enables, word address, write
//                data, PC for the write log, combinational read data)
//   wb_*       : registered load result into MEM/WB
//   exc_adel/s : registered address-exception pulses (load/store)
// master = surrounding pipeline and memory, slave = mem_access_unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic [4:0]  req_rd;
  logic        stall;
  logic        dm_memread;
  logic        dm_memwrite;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_pc;
  logic [31:0] dm_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic [31:0] wb_pc;
  logic        exc_adel;
  logic        exc_ades;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_pc, req_rd, dm_rdata,
    input  stall, dm_memread, dm_memwrite, dm_addr, dm_wdata, dm_pc,
           wb_valid, wb_data, wb_rd, wb_pc, exc_adel, exc_ades
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_pc, req_rd, dm_rdata,
    output stall, dm_memread, dm_memwrite, dm_addr, dm_wdata, dm_pc,
           wb_valid, wb_data, wb_rd, wb_pc, exc_adel, exc_ades
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store sequencer between EX/MEM and a word-wide data memory. Loads are
// extended and registered into MEM/WB; sh/sb become a read-modify-write whose
// write lands one cycle later while upstream is stalled; bad addresses raise
// a one-cycle exception pulse instead of touching memory.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : mem_access_unit_if.slave (request, dm port, MEM/WB, exceptions)
//
// state | meaning
// IDLE  | accept a request: load, sw, or read phase of sh/sb
// WRITE | write the latched merged word of a sh/sb, upstream stalled
module mem_access_unit #(
  parameter int DM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.slave  bus
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DM_WORDS);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t      state;
  logic [31:0] pend_addr;
  logic [31:0] pend_wdata;
  logic [31:0] pend_pc;

  logic        is_store;
  logic        is_word;
  logic        is_half;
  logic        addr_bad;
  logic        accept;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic [31:0] word_addr;

  always_comb begin
    is_store  = (bus.req_op == OP_SW) || (bus.req_op == OP_SH) || (bus.req_op == OP_SB);
    is_word   = (bus.req_op == OP_LW) || (bus.req_op == OP_SW);
    is_half   = (bus.req_op == OP_LH) || (bus.req_op == OP_LHU) || (bus.req_op == OP_SH);
    addr_bad  = (bus.req_addr >= ADDR_LIMIT)
             || (is_word && (bus.req_addr[1:0] != 2'b00))
             || (is_half && bus.req_addr[0]);
    accept    = (state == IDLE) && bus.req_valid && !addr_bad;
    word_addr = {bus.req_addr[31:2], 2'b00};

    byte_val  = bus.dm_rdata[{bus.req_addr[1:0], 3'b000} +: 8];
    half_val  = bus.dm_rdata[{bus.req_addr[1], 4'b0000} +: 16];

    case (bus.req_op)
      OP_LH:   load_data = {{16{half_val[15]}}, half_val};
      OP_LHU:  load_data = {16'h0000, half_val};
      OP_LB:   load_data = {{24{byte_val[7]}}, byte_val};
      OP_LBU:  load_data = {24'h000000, byte_val};
      default: load_data = bus.dm_rdata;
    endcase

    merged = bus.dm_rdata;
    if (bus.req_op == OP_SB)
      merged[{bus.req_addr[1:0], 3'b000} +: 8] = bus.req_wdata[7:0];
    else
      merged[{bus.req_addr[1], 4'b0000} +: 16] = bus.req_wdata[15:0];
  end

  // Enables are gated by reset so a pending RMW write is dropped on reset.
  assign bus.stall       = (state == WRITE);
  assign bus.dm_memread  = !reset && accept && (bus.req_op != OP_SW);
  assign bus.dm_memwrite = !reset && ((state == WRITE) || (accept && (bus.req_op == OP_SW)));
  assign bus.dm_addr     = (state == WRITE) ? pend_addr  : word_addr;
  assign bus.dm_wdata    = (state == WRITE) ? pend_wdata : bus.req_wdata;
  assign bus.dm_pc       = (state == WRITE) ? pend_pc    : bus.req_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pend_addr    <= '0;
      pend_wdata   <= '0;
      pend_pc      <= '0;
      bus.wb_valid <= 1'b0;
      bus.wb_data  <= '0;
      bus.wb_rd    <= '0;
      bus.wb_pc    <= '0;
      bus.exc_adel <= 1'b0;
      bus.exc_ades <= 1'b0;
    end else begin
      bus.wb_valid <= 1'b0;
      bus.exc_adel <= 1'b0;
      bus.exc_ades <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (addr_bad) begin
              bus.exc_adel <= !is_store;
              bus.exc_ades <= is_store;
            end else if (!is_store) begin
              bus.wb_valid <= 1'b1;
              bus.wb_data  <= load_data;
              bus.wb_rd    <= bus.req_rd;
              bus.wb_pc    <= bus.req_pc;
            end else if (bus.req_op != OP_SW) begin
              pend_addr  <= word_addr;
              pend_wdata <= merged;
              pend_pc    <= bus.req_pc;
              state      <= WRITE;
            end
          end
        end
        WRITE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the EX/MEM pipeline register and the word-wide data memory `dm`.
- Loads: sign/zero-extends bytes and halfwords and registers the result into MEM/WB.
- Stores: converts `sb`/`sh` into a two-cycle read-modify-write, since `dm` only writes whole words.
- Flags misaligned or out-of-range addresses as address exceptions instead of touching memory.
- Freezes the upstream pipeline for one cycle per sub-word store.

## Interface
Parameters:
- `DM_WORDS`, default 1024: dm depth in words. The valid byte range is `0 .. 4*DM_WORDS-1`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: a memory instruction is present this cycle.
- `req_op` in 3: operation code. 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb.
- `req_addr` in 32: byte address (ALU result).
- `req_wdata` in 32: store data, right-aligned (rt value).
- `req_pc` in 32: PC of the instruction.
- `req_rd` in 5: load destination register.
- `stall` out 1: upstream must hold its request and freeze.
- `dm_memread` out 1: dm read enable.
- `dm_memwrite` out 1: dm write enable.
- `dm_addr` out 32: word address to dm, with bits [1:0] = 0.
- `dm_wdata` out 32: full word to write.
- `dm_pc` out 32: PC forwarded to dm for its write log.
- `dm_rdata` in 32: dm combinational read data.
- `wb_valid` out 1: registered; a load result is valid.
- `wb_data` out 32: registered, extended load result.
- `wb_rd` out 5: registered destination register.
- `wb_pc` out 32: registered PC.
- `exc_adel` out 1: registered load address exception, one-cycle pulse.
- `exc_ades` out 1: registered store address exception, one-cycle pulse.

## Operation
State machine: IDLE, WRITE. Reset enters IDLE.

Address check, evaluated in IDLE when `req_valid` is high. The access is bad if any of these hold:
- `req_addr >= 4*DM_WORDS`.
- lw/sw with `addr[1:0] != 0`.
- lh/lhu/sh with `addr[0] != 0`.

A bad load raises `exc_adel`; a bad store raises `exc_ades`. A bad access drives no dm enable and leaves `wb_valid` = 0.

Operations in IDLE:
- **Aligned load:** `dm_memread`=1, `dm_addr`={addr[31:2],2'b00}.
  - Byte lane = `addr[1:0]`: lane 0 = bits [7:0], lane 3 = bits [31:24].
  - Halfword lane = `addr[1]`: 0 = [15:0], 1 = [31:16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
  - On the next edge: `wb_valid`=1, with `wb_data`/`wb_rd`/`wb_pc` captured.
- **sw:** `dm_memwrite`=1, `dm_wdata`=`req_wdata`, `dm_pc`=`req_pc`. Stays in IDLE.
- **sh/sb:** `dm_memread`=1.
  - The unit merges `req_wdata[15:0]` or `[7:0]` into `dm_rdata` at the selected lane.
  - It latches the merged word, word address and PC into internal registers, then goes to WRITE.
- **No request** (`req_valid`=0): all dm enables 0, `wb_valid` goes 0.

WRITE state:
- Drives `dm_memwrite`=1 with the latched address, merged word and PC.
- `stall`=1 and `dm_memread`=0.
- Any `req_valid` is ignored because upstream is holding.
- Returns to IDLE on the next edge.

Stores and faulting accesses clear `wb_valid` on the next edge.

## Timing
- `stall` = (state == WRITE), combinational. It is never high in IDLE.
- Load-to-use latency: the result is visible on `wb_*` one cycle after the request cycle.
- sw: the dm write happens in the request cycle.
- sh/sb: the dm write happens one cycle after the request cycle, with a single stall cycle in between.
- Back-to-back sh followed by lb to the same word: the lb issues in the cycle after WRITE, so it reads the merged data. No forwarding is needed.
- dm enables are combinational from request/state and are forced to 0 while `reset`=1.
- Reset in WRITE:
  - The pending write is discarded; `dm_memwrite` stays 0 that cycle.
  - The state returns to IDLE.
  - Memory keeps its pre-merge value.
- Register reset values after reset:
  - `wb_valid`=0, `wb_data`=0, `wb_rd`=0, `wb_pc`=0.
  - `exc_adel`=0, `exc_ades`=0, state=IDLE.
- Exception outputs pulse for exactly one cycle per faulting request.

## Test plan
- dm word 0x10 = 0x8899AABB, then lb 0x11 → `wb_data`=0xFFFFFFAA one cycle later; lbu 0x11 → 0x000000AA; lh 0x12 → 0xFFFF8899; lhu 0x12 → 0x00008899.
- sw 0xDEADBEEF @0x20 → `dm_memwrite`=1 in the same cycle, `stall` never high; a following lw 0x20 → `wb_data`=0xDEADBEEF.
- word @0x30 = 0x11223344, then sb 0x55 @0x31 → `stall` high for exactly 1 cycle; lw 0x30 → 0x11225544. Then sh 0xABCD @0x32 → lw 0x30 gives 0xABCD5544.
- lw @0x22, sh @0x23, lb @0x1000 (DM_WORDS=1024) → `exc_adel`/`exc_ades`/`exc_adel` each pulse 1 cycle; no dm enable asserted; `wb_valid`=0.
- sb issued, `reset` asserted during the WRITE cycle → no `dm_memwrite` that cycle; target word unchanged; all outputs 0 and state IDLE the next cycle.
- Idle with `req_valid`=0 for 3 cycles after a load → `wb_valid` drops to 0 the cycle after the load result; dm enables stay 0.
